// File: rtl/dut_bit_regfile_pkg.sv
// Shared constants and types for the 8 x 1-bit register file.
package dut_bit_regfile_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 1;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/dut_bit_regfile_if.sv
// Write and read method signals of the register file, each with enable/ready.
interface dut_bit_regfile_if;
    import dut_bit_regfile_pkg::*;

    addr_t write_address;
    data_t write_data;
    logic  write_en;
    logic  write_rdy;
    addr_t read_address;
    logic  read_en;
    data_t read_data;
    logic  read_rdy;

    modport master (
        output write_address, write_data, write_en, read_address, read_en,
        input  write_rdy, read_data, read_rdy
    );

    modport slave (
        input  write_address, write_data, write_en, read_address, read_en,
        output write_rdy, read_data, read_rdy
    );
endinterface

// File: rtl/dut_bit_regfile.sv
// 8 x 1-bit register file: synchronous clearable storage, registered ready,
// zero-latency read-before-write read port.
module dut_bit_regfile
    import dut_bit_regfile_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    dut_bit_regfile_if.slave   bus
);

    data_t r_mem [DEPTH];
    logic  r_rdy;
    logic  w_wr_fire;
    logic  w_read_en_unused;

    assign w_wr_fire        = bus.write_en & r_rdy;
    // read_en only qualifies the read transaction; it has no effect on state
    assign w_read_en_unused = bus.read_en;

    // RST_N is active-high despite its name; reset wins over a same-edge write
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            r_rdy <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_rdy <= 1'b1;
            if (w_wr_fire) begin
                r_mem[bus.write_address] <= bus.write_data;
            end
        end
    end

    assign bus.write_rdy = r_rdy;
    assign bus.read_rdy  = r_rdy;
    assign bus.read_data = r_rdy ? r_mem[bus.read_address] : '0;

endmodule

// File: tb/tb_dut_bit_regfile.sv
// Directed testbench for dut_bit_regfile.
module tb_dut_bit_regfile;
    import dut_bit_regfile_pkg::*;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    dut_bit_regfile_if bus ();

    dut_bit_regfile u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b1;
        tick();
        checks++;
        if (bus.write_rdy !== 1'b0 || bus.read_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy_edge1 got w=%b r=%b want 0/0", bus.write_rdy, bus.read_rdy);
        end
        tick();
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.write_rdy !== 1'b0 || bus.read_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy_after got w=%b r=%b want 0/0", bus.write_rdy, bus.read_rdy);
        end
        tick();
        checks++;
        if (bus.write_rdy !== 1'b1 || bus.read_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy_release got w=%b r=%b want 1/1", bus.write_rdy, bus.read_rdy);
        end
        bus.read_en = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.read_address = addr_t'(a);
            #1;
            checks++;
            if (bus.read_data !== 1'b0) begin
                failures++;
                $display("FAIL reset_read addr=%0d got %b want 0", a, bus.read_data);
            end
        end
        bus.read_en = 1'b0;
    endtask

    task automatic test_write_readback();
        logic [7:0] exp_pat;
        exp_pat = 8'b1010_1010;
        for (int a = 1; a < DEPTH; a += 2) begin
            bus.write_en      = 1'b1;
            bus.write_address = addr_t'(a);
            bus.write_data    = 1'b1;
            tick();
        end
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.read_address = addr_t'(a);
            #1;
            checks++;
            if (bus.read_data !== exp_pat[a]) begin
                failures++;
                $display("FAIL readback addr=%0d got %b want %b", a, bus.read_data, exp_pat[a]);
            end
        end
        bus.read_en = 1'b0;
    endtask

    task automatic test_overwrite();
        bus.write_en      = 1'b1;
        bus.write_address = 3'd4;
        bus.write_data    = 1'b1;
        tick();
        bus.write_data   = 1'b0;
        bus.read_en      = 1'b1;
        bus.read_address = 3'd4;
        #1;
        checks++;
        if (bus.read_data !== 1'b1) begin
            failures++;
            $display("FAIL overwrite_first got %b want 1", bus.read_data);
        end
        tick();
        bus.write_en = 1'b0;
        #1;
        checks++;
        if (bus.read_data !== 1'b0) begin
            failures++;
            $display("FAIL overwrite_second got %b want 0", bus.read_data);
        end
        bus.read_en = 1'b0;
    endtask

    task automatic test_read_before_write();
        bus.write_en      = 1'b1;
        bus.write_address = 3'd2;
        bus.write_data    = 1'b1;
        bus.read_en       = 1'b1;
        bus.read_address  = 3'd2;
        #1;
        checks++;
        if (bus.read_data !== 1'b0) begin
            failures++;
            $display("FAIL rbw_same_cycle got %b want 0", bus.read_data);
        end
        tick();
        bus.write_en = 1'b0;
        #1;
        checks++;
        if (bus.read_data !== 1'b1) begin
            failures++;
            $display("FAIL rbw_next_cycle got %b want 1", bus.read_data);
        end
        bus.read_en = 1'b0;
    endtask

    task automatic test_write_before_ready();
        RST_N             = 1'b1;
        bus.write_en      = 1'b1;
        bus.write_address = 3'd6;
        bus.write_data    = 1'b1;
        tick();
        RST_N = 1'b0;
        #1;
        checks++;
        if (bus.write_rdy !== 1'b0) begin
            failures++;
            $display("FAIL wbr_rdy_low got %b want 0", bus.write_rdy);
        end
        tick();
        bus.write_en = 1'b0;
        #1;
        checks++;
        if (bus.write_rdy !== 1'b1) begin
            failures++;
            $display("FAIL wbr_rdy_high got %b want 1", bus.write_rdy);
        end
        bus.read_en      = 1'b1;
        bus.read_address = 3'd6;
        #1;
        checks++;
        if (bus.read_data !== 1'b0) begin
            failures++;
            $display("FAIL wbr_addr6 got %b want 0", bus.read_data);
        end
        bus.read_en = 1'b0;
    endtask

    task automatic test_reset_midrun();
        for (int a = 0; a < DEPTH; a++) begin
            bus.write_en      = 1'b1;
            bus.write_address = addr_t'(a);
            bus.write_data    = 1'b1;
            tick();
        end
        bus.write_en     = 1'b0;
        bus.read_en      = 1'b1;
        bus.read_address = 3'd5;
        #1;
        checks++;
        if (bus.read_data !== 1'b1) begin
            failures++;
            $display("FAIL midrun_filled got %b want 1", bus.read_data);
        end
        RST_N             = 1'b1;
        bus.write_en      = 1'b1;
        bus.write_address = 3'd0;
        bus.write_data    = 1'b1;
        tick();
        RST_N        = 1'b0;
        bus.write_en = 1'b0;
        #1;
        checks++;
        if (bus.read_rdy !== 1'b0 || bus.read_data !== 1'b0) begin
            failures++;
            $display("FAIL midrun_rdy_low got rdy=%b data=%b want 0/0", bus.read_rdy, bus.read_data);
        end
        tick();
        checks++;
        if (bus.read_rdy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_rdy_back got %b want 1", bus.read_rdy);
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.read_address = addr_t'(a);
            #1;
            checks++;
            if (bus.read_data !== 1'b0) begin
                failures++;
                $display("FAIL midrun_clear addr=%0d got %b want 0", a, bus.read_data);
            end
        end
        bus.read_en = 1'b0;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        RST_N             = 1'b1;
        bus.write_en      = 1'b0;
        bus.write_address = '0;
        bus.write_data    = '0;
        bus.read_en       = 1'b0;
        bus.read_address  = '0;

        test_reset();
        test_write_readback();
        test_overwrite();
        test_read_before_write();
        test_write_before_ready();
        test_reset_midrun();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dut_bit_regfile.md
Name: dut_bit_regfile

Overview:
- Small register file: 8 entries × 1 bit.
- One write port and one read port, each a Bluespec-style method with enable and ready signals.
- Sits directly under a top-level wrapper that supplies a free-running clock and drives both ports from the test environment.
- Intended as a simple storage DUT for simulation and regression flows.

Parameters:
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W = 8 entries.
- DATA_W, 1, width of each entry.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  reset; synchronous, active-high (port name kept per codebase convention; asserted = 1).
- write_address  input  ADDR_W  entry selected for write.
- write_data  input  DATA_W  value to store.
- write_en  input  1  write method enable.
- write_rdy  output  1  write method ready.
- read_address  input  ADDR_W  entry selected for read.
- read_en  input  1  read method enable (actionvalue).
- read_data  output  DATA_W  value of the selected entry.
- read_rdy  output  1  read method ready.

Behaviour:
- Storage: DEPTH registers of DATA_W bits.
- Reset: on a rising CLK edge with RST_N=1, all entries are cleared to 0.
- Ready signals: write_rdy and read_rdy are registered.
  - Both are 0 during, and in the cycle after, any reset edge.
  - Both become 1 on the first edge where RST_N=0.
  - Both stay 1 until the next reset.
- Write:
  - On a rising edge with write_en=1, write_rdy=1 and RST_N=0: mem[write_address] <= write_data.
  - write_en while write_rdy=0 is ignored; no state change.
- Read:
  - read_data = mem[read_address], combinational, same cycle (zero latency).
  - read_data is valid whenever read_rdy=1; read_en only qualifies the transaction and has no state side-effect.
  - When read_rdy=0, read_data is driven to 0.
- Same-cycle write and read to the same address:
  - read_data returns the old value (read-before-write).
  - The new value is visible from the next cycle.
- Reset mid-operation: reset takes priority over a simultaneous write. Entries are cleared and the write is dropped.
- Address range: all 8 addresses are valid, so there is no out-of-range case. X/Z on the address is not defined behaviour.
- No other outputs; no internal state machine beyond the ready flag.

Decomposition:
- Shared package holds ADDR_W, DATA_W and DEPTH constants, plus typedefs addr_t (logic [ADDR_W-1:0]) and data_t (logic [DATA_W-1:0]).
- Single module, no sub-modules. Storage is a plain register array rather than an inferred RAM, so that synchronous clear is possible.

Test Plan:
- Reset: hold RST_N=1 for 2 cycles, then release -> rdy signals 0 during reset and 1 one cycle after release; reading addresses 0..7 returns 0.
- Write/readback: write 1 to addresses 1, 3, 5, 7 (one per cycle), then read 0..7 -> read_data = 0,1,0,1,0,1,0,1.
- Overwrite: write 1 to address 4, then 0 to address 4 -> next-cycle read of address 4 returns 0.
- Read-before-write: in one cycle, write 1 to address 2 and read address 2 -> read_data=0 in that cycle, 1 in the following cycle.
- Write before ready: assert write_en (address 6, data 1) during reset and in the first post-reset cycle where rdy=0 -> address 6 reads 0 afterwards.
- Reset mid-run: fill all entries with 1, assert RST_N=1 for one edge together with write_en (address 0, data 1) -> all entries read 0 after rdy returns to 1.
